// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO result stage and the divider control codes.
// Optional feature macro: HILO_BYPASS_EN (MFHI/MFLO served from dataIn in CAPTURE).
package hilo_pkg;

   localparam int unsigned SIG_W          = 6;
   localparam int unsigned CNT_W          = 6;
   localparam int unsigned DIV_CYCLES_DEF = 32;

   // Control codes, shared with the divider
   localparam logic [SIG_W-1:0] DIVU = 6'b011011;
   localparam logic [SIG_W-1:0] OUT  = 6'b111111;
   localparam logic [SIG_W-1:0] MFHI = 6'b010000;
   localparam logic [SIG_W-1:0] MFLO = 6'b010010;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_DONE    = 2'd2,
      ST_CAPTURE = 2'd3
   } hilo_state_e;

   // True for either HI/LO read code
   function automatic logic is_read(input logic [SIG_W-1:0] sig);
      return (sig == MFHI) || (sig == MFLO);
   endfunction

endpackage

// File: rtl/div_cycle_counter.sv
// Loadable 6-bit down-counter tracking divide latency; saturates at zero.
module div_cycle_counter
   import hilo_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   // Load has priority; decrement only while enabled and non-zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/hilo_register.sv
// HI/LO register stage behind the divider: tracks a DIVU in flight, captures
// {quotient, remainder} on OUT, serves MFHI/MFLO and stalls early reads.
// Optional feature macro: HILO_BYPASS_EN (reads in CAPTURE served from dataIn).
module hilo_register
   import hilo_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int unsigned WIDTH      = 32
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SIG_W-1:0]     Signal,
   input  logic [2*WIDTH-1:0]   dataIn,
   output logic [WIDTH-1:0]     dataOut,
   output logic                 valid,
   output logic                 busy,
   output logic                 ready,
   output logic                 stall
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_CYCLES - 1);

   hilo_state_e      r_state;
   logic             r_busy;
   logic             r_ready;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic w_is_read;
   logic w_is_mfhi;
   logic w_read_ok;
   logic w_load;
   logic w_cnt_zero;

   assign w_is_read = is_read(Signal);
   assign w_is_mfhi = (Signal == MFHI);
   assign w_load    = (r_state == ST_IDLE) && (Signal == DIVU);

`ifdef HILO_BYPASS_EN
   // CAPTURE reads are forwarded straight from the divider result
   assign w_read_ok = (r_state == ST_IDLE) || (r_state == ST_CAPTURE);
`else
   assign w_read_ok = (r_state == ST_IDLE);
`endif

   assign stall = w_is_read && !w_read_ok;

   div_cycle_counter u_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_en       (r_state == ST_BUSY),
      .i_load_val (LOAD_VAL),
      .o_zero     (w_cnt_zero)
   );

   // Divide-tracking FSM with registered busy/ready and HI/LO capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_load) begin
                  r_state <= ST_BUSY;
                  r_busy  <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (w_cnt_zero) begin
                  r_state <= ST_DONE;
                  r_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               if (Signal == OUT) begin
                  r_state <= ST_CAPTURE;
                  r_ready <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               // Quotient lands in LO, remainder in HI
               r_lo    <= dataIn[2*WIDTH-1:WIDTH];
               r_hi    <= dataIn[WIDTH-1:0];
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // Read port: one-cycle valid pulse, dataOut holds between reads
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataOut <= '0;
         valid   <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (w_is_read && w_read_ok) begin
            valid <= 1'b1;
            if (r_state == ST_CAPTURE) begin
               dataOut <= w_is_mfhi ? dataIn[WIDTH-1:0] : dataIn[2*WIDTH-1:WIDTH];
            end else begin
               dataOut <= w_is_mfhi ? r_hi : r_lo;
            end
         end
      end
   end

   assign busy  = r_busy;
   assign ready = r_ready;

endmodule

// File: tb/tb_hilo_register.sv
// Directed bench for hilo_register: reset, divide latency, stalls, capture and reads.
module tb_hilo_register;
   import hilo_pkg::*;

   localparam int unsigned DC = 32;
   localparam int unsigned W  = 32;
   localparam logic [5:0]  NOP = 6'd0;

   logic          clk;
   logic          reset;
   logic [5:0]    sig;
   logic [63:0]   din;
   logic [31:0]   dout;
   logic          valid;
   logic          busy;
   logic          ready;
   logic          stall;

   int n_checks = 0;
   int n_errs   = 0;
   int ready_at;
   int cyc;

   hilo_register #(.DIV_CYCLES(DC), .WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .Signal  (sig),
      .dataIn  (din),
      .dataOut (dout),
      .valid   (valid),
      .busy    (busy),
      .ready   (ready),
      .stall   (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue DIVU, then count edges until ready rises (bounded)
   task automatic start_div(input logic [63:0] d, output int edges);
      edges = 0;
      din = d;
      sig = DIVU;
      tick;
      sig = NOP;
      for (int k = 1; k <= 100; k++) begin
         tick;
         if (ready) begin
            edges = k;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      sig   = NOP;
      din   = '0;
      tick;
      tick;
      chk("rst_dout",  64'(dout),  64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      reset = 1'b1;
      tick;

      // Reads straight after reset return zero
      sig = MFHI;
      #1;
      chk("idle_stall", 64'(stall), 64'd0);
      tick;
      chk("mfhi0_valid", 64'(valid), 64'd1);
      chk("mfhi0_dout",  64'(dout),  64'd0);
      sig = MFLO;
      tick;
      chk("mflo0_valid", 64'(valid), 64'd1);
      chk("mflo0_dout",  64'(dout),  64'd0);
      sig = NOP;
      tick;
      chk("nop_valid", 64'(valid), 64'd0);
      chk("idle_busy", 64'(busy),  64'd0);

      // Divide 1: stalled read, ignored DIVU/OUT in BUSY, latency check
      din = 64'h0000_0007_0000_0002;
      sig = DIVU;
      tick;
      chk("div1_busy",  64'(busy),  64'd1);
      chk("div1_ready", 64'(ready), 64'd0);
      ready_at = 0;
      for (int k = 1; k <= 40 && ready_at == 0; k++) begin
         case (k)
            5:       sig = MFLO;
            8:       sig = DIVU;
            12:      sig = OUT;
            default: sig = NOP;
         endcase
         #1;
         if (k == 5) chk("busy_stall", 64'(stall), 64'd1);
         tick;
         if (k == 5) chk("busy_read_valid", 64'(valid), 64'd0);
         if (ready) ready_at = k;
      end
      chk("div1_latency", 64'(ready_at), 64'(DC));

      // DONE: reads stall, DIVU ignored, wait for OUT
      sig = MFLO;
      #1;
      chk("done_stall", 64'(stall), 64'd1);
      tick;
      chk("done_read_valid", 64'(valid), 64'd0);
      chk("done_ready_hold", 64'(ready), 64'd1);
      sig = DIVU;
      tick;
      chk("done_divu_ign", 64'(ready), 64'd1);
      sig = OUT;
      tick;
      chk("cap_ready", 64'(ready), 64'd0);
      chk("cap_busy",  64'(busy),  64'd1);
      sig = NOP;
      tick;
      chk("post_cap_busy", 64'(busy), 64'd0);
      sig = MFLO;
      tick;
      chk("mflo1_valid", 64'(valid), 64'd1);
      chk("mflo1_dout",  64'(dout),  64'd7);
      sig = MFHI;
      tick;
      chk("mfhi1_dout", 64'(dout), 64'd2);
      sig = NOP;
      tick;
      chk("hold_valid", 64'(valid), 64'd0);
      chk("hold_dout",  64'(dout),  64'd2);

      // Divide 2: MFHI issued in the CAPTURE cycle
      start_div(64'h0000_0004_0000_0009, cyc);
      chk("div2_latency", 64'(cyc), 64'(DC));
      sig = OUT;
      tick;
      sig = MFHI;
      #1;
`ifdef HILO_BYPASS_EN
      chk("cap_read_stall", 64'(stall), 64'd0);
      tick;
      chk("cap_read_valid", 64'(valid), 64'd1);
      chk("cap_read_dout",  64'(dout),  64'd9);
`else
      chk("cap_read_stall", 64'(stall), 64'd1);
      tick;
      chk("cap_read_valid", 64'(valid), 64'd0);
      chk("cap_read_dout",  64'(dout),  64'd2);
`endif
      sig = MFLO;
      tick;
      chk("mflo2_dout", 64'(dout), 64'd4);
      sig = MFHI;
      tick;
      chk("mfhi2_dout", 64'(dout), 64'd9);

      // Divide 3 sets HI=3, then reset aborts divide 4 mid-flight
      start_div(64'h0000_0001_0000_0003, cyc);
      sig = OUT;
      tick;
      sig = NOP;
      tick;
      sig = MFHI;
      tick;
      chk("mfhi3_dout", 64'(dout), 64'd3);
      sig = DIVU;
      tick;
      sig = NOP;
      repeat (9) tick;
      chk("pre_rst_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_dout",  64'(dout),  64'd0);
      chk("mid_rst_valid", 64'(valid), 64'd0);
      chk("mid_rst_busy",  64'(busy),  64'd0);
      chk("mid_rst_ready", 64'(ready), 64'd0);
      sig = MFHI;
      #1;
      chk("mid_rst_stall", 64'(stall), 64'd0);
      reset = 1'b1;
      tick;
      chk("post_rst_valid", 64'(valid), 64'd1);
      chk("post_rst_hi",    64'(dout),  64'd0);
      chk("post_rst_busy",  64'(busy),  64'd0);
      sig = MFLO;
      din = 64'hFFFF_FFFF_FFFF_FFFF;
      tick;
      chk("post_rst_lo", 64'(dout), 64'd0);
      sig = NOP;
      tick;

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/hilo_register.md
# hilo_register

HI/LO result register stage that sits directly downstream of the divider. It tracks a DIVU in flight with a cycle counter and captures the divider's 64-bit {quotient, remainder} result when the control unit issues OUT. It then serves MFHI/MFLO reads to the datapath and raises a stall when a read arrives before the result is committed.

## Interface
- DIV_CYCLES, 32, cycles from DIVU acceptance until OUT may be issued (legal range 1..63)
- WIDTH, 32, HI/LO register width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- Signal  in  6  control code: DIVU=27 (6'b011011), OUT=63 (6'b111111), MFHI=16 (6'b010000), MFLO=18 (6'b010010); all others = no-op
- dataIn  in  64  divider result: [63:32] quotient, [31:0] remainder
- dataOut  out  32  registered HI or LO read value
- valid  out  1  dataOut holds a completed MFHI/MFLO read (one-cycle pulse)
- busy  out  1  divide in flight (state != IDLE)
- ready  out  1  counter expired, OUT may be issued (state == DONE)
- stall  out  1  combinational; MFHI/MFLO this cycle cannot be served

## Operation
- States: IDLE, BUSY, DONE, CAPTURE.
- IDLE: DIVU -> load counter with DIV_CYCLES-1, go BUSY. MFHI/MFLO served. OUT ignored.
- BUSY: counter decrements each cycle; at 0 go DONE. DIVU/OUT ignored.
- DONE: wait indefinitely for OUT; OUT -> go CAPTURE. DIVU ignored.
- CAPTURE: one cycle; latch LO <= dataIn[63:32] (quotient), HI <= dataIn[31:0] (remainder); go IDLE.
- Reads: MFHI -> dataOut <= HI, MFLO -> dataOut <= LO, valid <= 1 next cycle; otherwise valid <= 0, dataOut holds.
- stall = (Signal is MFHI or MFLO) and state != IDLE (see Configuration for CAPTURE). Stalled reads have no effect; requester reissues.
- DIVU while busy never restarts the counter; HI/LO unchanged until CAPTURE.
- No arithmetic besides the counter; counter width 6 bits, never wraps (stops at 0).

## Timing
- Reset (reset=0, any time, asynchronous): state IDLE, counter 0, HI=LO=0, dataOut=0, valid=0; busy=ready=stall=0.
- Reset mid-divide discards the operation; HI/LO return to 0.
- DIVU at edge t -> busy=1 from t+1; ready=1 from t+DIV_CYCLES.
- OUT at edge t in DONE -> CAPTURE during t+1 (divider's registered dataOut valid), HI/LO updated at edge t+1, IDLE from t+2.
- MFHI/MFLO in IDLE at edge t -> valid=1, dataOut valid during cycle t+1.
- A read in the same cycle as DIVU in IDLE is impossible (one Signal); a read in the CAPTURE cycle follows Configuration.

## Configuration
- HILO_BYPASS_EN defined: MFHI/MFLO in CAPTURE is not stalled; dataOut <= dataIn[31:0] (MFHI) or dataIn[63:32] (MFLO), valid=1 next cycle.
- Undefined: stall=1 in CAPTURE as in BUSY/DONE; first servable read is in IDLE one cycle later.

## Structure
- Package hilo_pkg: Signal code constants (DIVU, OUT, MFHI, MFLO), state enum, DIV_CYCLES default; the divider shares the code constants.
- One sub-module: div_cycle_counter (loadable 6-bit down-counter with load, enable, zero flag).

## Test plan
- Reset then MFHI, MFLO -> valid pulses, dataOut=0 both times; busy=0.
- DIVU with DIV_CYCLES=32, dataIn=64'h0000_0007_0000_0002 -> ready=1 exactly 32 cycles after DIVU; OUT -> MFLO returns 7, MFHI returns 2.
- MFLO at cycle 5 of BUSY and in DONE -> stall=1, valid=0, LO unchanged.
- DIVU reissued during BUSY and OUT issued in BUSY -> ignored; ready timing unchanged from first DIVU.
- reset asserted at BUSY cycle 10 after prior result HI=3 -> all outputs 0, IDLE; subsequent MFHI returns 0.
- MFHI in CAPTURE cycle, dataIn remainder=9 -> with HILO_BYPASS_EN valid=1, dataOut=9 next cycle; without it stall=1.
